// File: rtl/nios_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares them to build-time values.
// Latency: 4 cycles from launch to done with a zero-wait slave; each stalled cycle adds one.
// Backpressure: honours avm_waitrequest and holds address/read stable; a per-read timeout forces a verdict.
module nios_sysid_checker #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1623339487,
  parameter int unsigned TIMEOUT_CYCLES = 256,  // legal range 1..65535
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter value at which the next stalled cycle is the last one allowed.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TS_ADDR  = BASE_ADDR + 32'd4;

  state_t      state;
  state_t      state_nxt;
  logic        launch_pend;
  logic [15:0] tmo_cnt;

  // Next-cycle values of the registered bus/status outputs.
  logic        read_d;
  logic [31:0] addr_d;
  logic        busy_d;
  logic        done_d;

  // Qualified events derived from the current state and bus inputs.
  logic        in_read;
  logic        stall;
  logic        xfer_ok;
  logic        tmo_hit;
  logic        launch;

  // Bus activity and launch decode for the current cycle.
  always_comb begin
    in_read = (state == RD_ID) || (state == RD_TS);
    stall   = in_read && avm_waitrequest;
    xfer_ok = in_read && !avm_waitrequest;
    tmo_hit = stall && (tmo_cnt == TMO_LAST);
    launch  = ((state == IDLE) && (start || launch_pend)) ||
              ((state == DONE) && start);
  end

  // State register; also arms the one-shot post-reset launch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      launch_pend <= AUTO_START;
    end else begin
      state       <= state_nxt;
      launch_pend <= 1'b0;
    end
  end

  // Next-state logic: start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RD_ID;
      RD_ID:   begin
                 if (tmo_hit)      state_nxt = DONE;
                 else if (xfer_ok) state_nxt = RD_TS;
               end
      RD_TS:   begin
                 if (tmo_hit)      state_nxt = DONE;
                 else if (xfer_ok) state_nxt = CMP;
               end
      CMP:     state_nxt = DONE;
      DONE:    if (launch) state_nxt = RD_ID;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so bus outputs come straight from flops.
  always_comb begin
    read_d = 1'b0;
    addr_d = 32'h0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      RD_ID: begin
        read_d = 1'b1;
        addr_d = BASE_ADDR;
        busy_d = 1'b1;
      end
      RD_TS: begin
        read_d = 1'b1;
        addr_d = TS_ADDR;
        busy_d = 1'b1;
      end
      CMP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset clears them without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      avm_read    <= read_d;
      avm_address <= addr_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Per-read stall counter, restarted whenever a read state is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 16'h0;
    end else if (state_nxt != state) begin
      tmo_cnt <= 16'h0;
    end else if (stall) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Capture the two words; values persist across checks until overwritten.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= 32'h0;
      ts_value <= 32'h0;
    end else if (xfer_ok) begin
      if (state == RD_ID) id_value <= avm_readdata;
      else                ts_value <= avm_readdata;
    end
  end

  // Verdict flags: cleared at launch, set by the compare or by a timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match   <= 1'b0;
      timeout <= 1'b0;
    end else if (launch) begin
      match   <= 1'b0;
      timeout <= 1'b0;
    end else if (tmo_hit) begin
      match   <= 1'b0;
      timeout <= 1'b1;
    end else if (state == CMP) begin
      match   <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
    end
  end

endmodule
